// File: rtl/rtsnoc_pkg.sv
// Shared widths, header field offsets and FSM encodings for the rtsnoc port arbiter.
// No logic, so no latency.
// No handshakes of its own.
package rtsnoc_pkg;

    // Width of the two {x,y} pairs in a header.
    function automatic int soc_xy_size(input int sx, input int sy);
        return 2 * sy + 2 * sx;
    endfunction

    // Header is both {x,y} pairs plus the two 3-bit h fields.
    function automatic int noc_header_size(input int sx, input int sy);
        return soc_xy_size(sx, sy) + 6;
    endfunction

    // Full flit width.
    function automatic int noc_bus_size(input int sx, input int sy, input int dw);
        return dw + noc_header_size(sx, sy);
    endfunction

    // Width of one {x,y,h} address.
    function automatic int noc_addr_width(input int sx, input int sy);
        return sx + sy + 3;
    endfunction

    // Bit offset of the destination {x,y,h} field.
    function automatic int noc_dst_lsb(input int dw);
        return dw;
    endfunction

    // Bit offset of the origin {x,y,h} field, which sits at the top of the flit.
    function automatic int noc_src_lsb(input int sx, input int sy, input int dw);
        return dw + noc_addr_width(sx, sy);
    endfunction

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_POP  = 1'b1
    } rx_state_t;

endpackage

// File: rtl/rtsnoc_rx_buf.sv
// One-entry flit buffer with a full flag, used to hold a flit for one client.
// Latency: a fill is visible on dout/full the cycle after the fill edge.
// Backpressure: the producer may fill only while empty; a pop while empty is ignored.
module rtsnoc_rx_buf #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         fill,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full
);

    // Capture on fill, release on pop; reset drops any held flit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
            full <= 1'b0;
        end else begin
            if (fill && !full) begin
                dout <= din;
                full <= 1'b1;
            end else if (pop && full) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rtsnoc_port_arbiter.sv
// Shares one router local port between two clients: round-robin TX, address-steered RX.
// Latency: TX accept to p_wr_o is 1 cycle; RX p_rd_o edge to cN_nd_o is 1 cycle.
// Backpressure: p_wait_i holds the registered TX flit; a full target buffer stalls all RX.
module rtsnoc_port_arbiter
    import rtsnoc_pkg::*;
#(
    parameter int SOC_SIZE_X     = 1,
    parameter int SOC_SIZE_Y     = 1,
    parameter int NOC_DATA_WIDTH = 16,
    parameter logic [SOC_SIZE_X+SOC_SIZE_Y+2:0] C1_SRC_ADDR = '0
) (
    input  logic                                                    clk_i,
    input  logic                                                    rst_i,
    output logic [noc_bus_size(SOC_SIZE_X,SOC_SIZE_Y,NOC_DATA_WIDTH)-1:0] p_din_o,
    output logic                                                    p_wr_o,
    output logic                                                    p_rd_o,
    input  logic [noc_bus_size(SOC_SIZE_X,SOC_SIZE_Y,NOC_DATA_WIDTH)-1:0] p_dout_i,
    input  logic                                                    p_wait_i,
    input  logic                                                    p_nd_i,
    input  logic [noc_bus_size(SOC_SIZE_X,SOC_SIZE_Y,NOC_DATA_WIDTH)-1:0] c0_din_i,
    input  logic                                                    c0_wr_i,
    output logic                                                    c0_wait_o,
    output logic [noc_bus_size(SOC_SIZE_X,SOC_SIZE_Y,NOC_DATA_WIDTH)-1:0] c0_dout_o,
    output logic                                                    c0_nd_o,
    input  logic                                                    c0_rd_i,
    input  logic [noc_bus_size(SOC_SIZE_X,SOC_SIZE_Y,NOC_DATA_WIDTH)-1:0] c1_din_i,
    input  logic                                                    c1_wr_i,
    output logic                                                    c1_wait_o,
    output logic [noc_bus_size(SOC_SIZE_X,SOC_SIZE_Y,NOC_DATA_WIDTH)-1:0] c1_dout_o,
    output logic                                                    c1_nd_o,
    input  logic                                                    c1_rd_i
);

    localparam int NOC_BUS_SIZE = noc_bus_size(SOC_SIZE_X, SOC_SIZE_Y, NOC_DATA_WIDTH);
    localparam int ADDR_W       = noc_addr_width(SOC_SIZE_X, SOC_SIZE_Y);
    localparam int SRC_LSB      = noc_src_lsb(SOC_SIZE_X, SOC_SIZE_Y, NOC_DATA_WIDTH);

    // ---------------- TX path ----------------
    tx_state_t tx_state;
    tx_state_t tx_state_nxt;
    logic      rr;
    logic      sel;
    logic      tx_accept;

    // Pick a requester (rr breaks ties only) and grant it combinationally while idle.
    always_comb begin
        tx_state_nxt = tx_state;
        sel          = 1'b0;
        tx_accept    = 1'b0;
        c0_wait_o    = 1'b1;
        c1_wait_o    = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (c0_wr_i && c1_wr_i) begin
                    sel = rr;
                end else begin
                    sel = c1_wr_i;
                end
                tx_accept = c0_wr_i | c1_wr_i;
                if (tx_accept) begin
                    c0_wait_o    = sel;
                    c1_wait_o    = ~sel;
                    tx_state_nxt = TX_SEND;
                end
            end
            TX_SEND: begin
                if (!p_wait_i) begin
                    tx_state_nxt = TX_IDLE;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // Register the granted flit toward the router and hold it until the router takes it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_state <= TX_IDLE;
            rr       <= 1'b0;
            p_din_o  <= '0;
            p_wr_o   <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            if (tx_accept) begin
                p_din_o <= sel ? c1_din_i : c0_din_i;
                p_wr_o  <= 1'b1;
                rr      <= ~sel;
            end else if (tx_state == TX_SEND && !p_wait_i) begin
                p_wr_o <= 1'b0;
            end
        end
    end

    // ---------------- RX path ----------------
    rx_state_t rx_state;
    rx_state_t rx_state_nxt;
    logic      tgt;
    logic      tgt_full;
    logic      fill0;
    logic      fill1;

    // Steer by origin address; read only when the target buffer has room, then skip one
    // cycle so the router can refresh p_nd_i before the next read.
    always_comb begin
        tgt          = (p_dout_i[SRC_LSB +: ADDR_W] == C1_SRC_ADDR);
        tgt_full     = tgt ? c1_nd_o : c0_nd_o;
        p_rd_o       = 1'b0;
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_IDLE: begin
                p_rd_o = p_nd_i & ~tgt_full;
                if (p_rd_o) begin
                    rx_state_nxt = RX_POP;
                end
            end
            RX_POP:  rx_state_nxt = RX_IDLE;
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    assign fill0 = p_rd_o & ~tgt;
    assign fill1 = p_rd_o &  tgt;

    // RX state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_state_nxt;
        end
    end

    rtsnoc_rx_buf #(.W(NOC_BUS_SIZE)) u_buf0 (
        .clk  (clk_i),
        .rst  (rst_i),
        .fill (fill0),
        .din  (p_dout_i),
        .pop  (c0_rd_i),
        .dout (c0_dout_o),
        .full (c0_nd_o)
    );

    rtsnoc_rx_buf #(.W(NOC_BUS_SIZE)) u_buf1 (
        .clk  (clk_i),
        .rst  (rst_i),
        .fill (fill1),
        .din  (p_dout_i),
        .pop  (c1_rd_i),
        .dout (c1_dout_o),
        .full (c1_nd_o)
    );

endmodule

// File: tb/tb_rtsnoc_port_arbiter.sv
module tb_rtsnoc_port_arbiter;

    localparam int B = 26;
    localparam logic [4:0] C1A = 5'h15;
    localparam logic [4:0] C0A = 5'h03;

    logic         clk;
    logic         rst;
    logic [B-1:0] p_din_o;
    logic         p_wr_o;
    logic         p_rd_o;
    logic [B-1:0] p_dout_i;
    logic         p_wait_i;
    logic         p_nd_i;
    logic [B-1:0] c0_din_i;
    logic         c0_wr_i;
    logic         c0_wait_o;
    logic [B-1:0] c0_dout_o;
    logic         c0_nd_o;
    logic         c0_rd_i;
    logic [B-1:0] c1_din_i;
    logic         c1_wr_i;
    logic         c1_wait_o;
    logic [B-1:0] c1_dout_o;
    logic         c1_nd_o;
    logic         c1_rd_i;

    int checks   = 0;
    int failures = 0;

    logic [B-1:0] tx_q[$];
    logic [B-1:0] rx_q0[$];
    logic [B-1:0] rx_q1[$];
    logic [B-1:0] exp_flit;

    rtsnoc_port_arbiter #(
        .SOC_SIZE_X     (1),
        .SOC_SIZE_Y     (1),
        .NOC_DATA_WIDTH (16),
        .C1_SRC_ADDR    (C1A)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .p_din_o   (p_din_o),
        .p_wr_o    (p_wr_o),
        .p_rd_o    (p_rd_o),
        .p_dout_i  (p_dout_i),
        .p_wait_i  (p_wait_i),
        .p_nd_i    (p_nd_i),
        .c0_din_i  (c0_din_i),
        .c0_wr_i   (c0_wr_i),
        .c0_wait_o (c0_wait_o),
        .c0_dout_o (c0_dout_o),
        .c0_nd_o   (c0_nd_o),
        .c0_rd_i   (c0_rd_i),
        .c1_din_i  (c1_din_i),
        .c1_wr_i   (c1_wr_i),
        .c1_wait_o (c1_wait_o),
        .c1_dout_o (c1_dout_o),
        .c1_nd_o   (c1_nd_o),
        .c1_rd_i   (c1_rd_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {orig[4:0], dst[4:0], data[15:0]}
    function automatic logic [B-1:0] mk(input logic [4:0] src, input logic [15:0] d);
        return {src, 5'h0A, d};
    endfunction

    task automatic drive_idle;
        p_dout_i = '0; p_wait_i = 1'b0; p_nd_i = 1'b0;
        c0_din_i = '0; c0_wr_i = 1'b0; c0_rd_i = 1'b0;
        c1_din_i = '0; c1_wr_i = 1'b0; c1_rd_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive_idle();
        #1;
        checks++;
        if ({p_wr_o, p_rd_o, c0_wait_o, c1_wait_o, c0_nd_o, c1_nd_o} !== 6'b001100) begin
            failures++;
            $display("FAIL reset_flags actual=%b expected=001100",
                     {p_wr_o, p_rd_o, c0_wait_o, c1_wait_o, c0_nd_o, c1_nd_o});
        end
        checks++;
        if ({p_din_o, c0_dout_o, c1_dout_o} !== '0) begin
            failures++;
            $display("FAIL reset_data actual=%h/%h/%h expected=0", p_din_o, c0_dout_o, c1_dout_o);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({p_wr_o, p_rd_o, c0_wait_o, c1_wait_o, c0_nd_o, c1_nd_o} !== 6'b001100) begin
            failures++;
            $display("FAIL idle_flags actual=%b expected=001100",
                     {p_wr_o, p_rd_o, c0_wait_o, c1_wait_o, c0_nd_o, c1_nd_o});
        end
    endtask

    task automatic test_single_write;
        @(negedge clk);
        c0_din_i = mk(C0A, 16'h1234);
        c0_wr_i  = 1'b1;
        p_wait_i = 1'b0;
        #1;
        checks++;
        if ({c0_wait_o, c1_wait_o} !== 2'b01) begin
            failures++;
            $display("FAIL single_grant actual=%b expected=01", {c0_wait_o, c1_wait_o});
        end
        tx_q.push_back(c0_din_i);
        @(negedge clk);
        c0_wr_i = 1'b0;
        #1;
        exp_flit = tx_q.pop_front();
        checks++;
        if (p_wr_o !== 1'b1 || p_din_o !== exp_flit) begin
            failures++;
            $display("FAIL single_tx actual=wr%b/%h expected=wr1/%h", p_wr_o, p_din_o, exp_flit);
        end
        @(negedge clk);
        #1;
        checks++;
        if (p_wr_o !== 1'b0) begin
            failures++;
            $display("FAIL single_wr_one_cycle actual=%b expected=0", p_wr_o);
        end
    endtask

    task automatic test_round_robin;
        logic exp_sel;
        int   hold;
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            c0_din_i = mk(C0A, 16'hA000 + 16'(k));
            c1_din_i = mk(C1A, 16'hB000 + 16'(k));
            c0_wr_i  = 1'b1;
            c1_wr_i  = 1'b1;
            p_wait_i = (k == 0);
            #1;
            exp_sel = (k % 2 == 1);
            checks++;
            if ({c0_wait_o, c1_wait_o} !== (exp_sel ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL rr_grant%0d actual=%b expected=%b", k, {c0_wait_o, c1_wait_o},
                         exp_sel ? 2'b10 : 2'b01);
            end
            tx_q.push_back(exp_sel ? c1_din_i : c0_din_i);
            @(negedge clk);
            c0_wr_i = 1'b0;
            c1_wr_i = 1'b0;
            #1;
            exp_flit = tx_q.pop_front();
            hold = (k == 0) ? 4 : 1;
            for (int c = 0; c < hold; c++) begin
                checks++;
                if (p_wr_o !== 1'b1 || p_din_o !== exp_flit) begin
                    failures++;
                    $display("FAIL rr_hold%0d_c%0d actual=wr%b/%h expected=wr1/%h",
                             k, c, p_wr_o, p_din_o, exp_flit);
                end
                if (c == hold - 1) p_wait_i = 1'b0;
                @(negedge clk);
                #1;
            end
            checks++;
            if (p_wr_o !== 1'b0) begin
                failures++;
                $display("FAIL rr_release%0d actual=%b expected=0", k, p_wr_o);
            end
        end
        // rr now points at c1, but a lone c0 request still wins.
        c0_din_i = mk(C0A, 16'hC0C0);
        c0_wr_i  = 1'b1;
        #1;
        checks++;
        if ({c0_wait_o, c1_wait_o} !== 2'b01) begin
            failures++;
            $display("FAIL lone_grant actual=%b expected=01", {c0_wait_o, c1_wait_o});
        end
        tx_q.push_back(c0_din_i);
        @(negedge clk);
        c0_wr_i = 1'b0;
        #1;
        exp_flit = tx_q.pop_front();
        checks++;
        if (p_wr_o !== 1'b1 || p_din_o !== exp_flit) begin
            failures++;
            $display("FAIL lone_tx actual=wr%b/%h expected=wr1/%h", p_wr_o, p_din_o, exp_flit);
        end
        @(negedge clk);
    endtask

    task automatic test_rx_steer;
        @(negedge clk);
        p_dout_i = mk(C1A, 16'hBEEF);
        p_nd_i   = 1'b1;
        #1;
        checks++;
        if (p_rd_o !== 1'b1) begin
            failures++;
            $display("FAIL steer_rd actual=%b expected=1", p_rd_o);
        end
        rx_q1.push_back(p_dout_i);
        @(negedge clk);
        p_nd_i   = 1'b0;
        p_dout_i = '0;
        #1;
        exp_flit = rx_q1.pop_front();
        checks++;
        if (p_rd_o !== 1'b0 || c1_nd_o !== 1'b1 || c1_dout_o !== exp_flit || c1_dout_o[15:0] !== 16'hBEEF) begin
            failures++;
            $display("FAIL steer_c1 actual=rd%b nd%b %h expected=rd0 nd1 %h",
                     p_rd_o, c1_nd_o, c1_dout_o, exp_flit);
        end
        checks++;
        if (c0_nd_o !== 1'b0) begin
            failures++;
            $display("FAIL steer_c0_empty actual=%b expected=0", c0_nd_o);
        end
        c1_rd_i = 1'b1;
        @(negedge clk);
        c1_rd_i = 1'b0;
        #1;
        checks++;
        if (c1_nd_o !== 1'b0) begin
            failures++;
            $display("FAIL steer_c1_pop actual=%b expected=0", c1_nd_o);
        end
    endtask

    task automatic test_rx_block;
        @(negedge clk);
        p_dout_i = mk(C0A, 16'hA5A5);
        p_nd_i   = 1'b1;
        #1;
        checks++;
        if (p_rd_o !== 1'b1) begin
            failures++;
            $display("FAIL block_first_rd actual=%b expected=1", p_rd_o);
        end
        rx_q0.push_back(p_dout_i);
        @(negedge clk);
        p_dout_i = mk(C0A, 16'h5A5A);
        #1;
        exp_flit = rx_q0.pop_front();
        checks++;
        if (c0_nd_o !== 1'b1 || c0_dout_o !== exp_flit || p_rd_o !== 1'b0) begin
            failures++;
            $display("FAIL block_c0_fill actual=nd%b %h rd%b expected=nd1 %h rd0",
                     c0_nd_o, c0_dout_o, p_rd_o, exp_flit);
        end
        @(negedge clk);
        #1;
        checks++;
        if (p_rd_o !== 1'b0) begin
            failures++;
            $display("FAIL block_full_rd actual=%b expected=0", p_rd_o);
        end
        @(negedge clk);
        c0_rd_i = 1'b1;
        #1;
        checks++;
        if (p_rd_o !== 1'b0) begin
            failures++;
            $display("FAIL block_pop_same_cycle actual=%b expected=0", p_rd_o);
        end
        @(negedge clk);
        c0_rd_i = 1'b0;
        #1;
        checks++;
        if (c0_nd_o !== 1'b0 || p_rd_o !== 1'b1) begin
            failures++;
            $display("FAIL block_resume actual=nd%b rd%b expected=nd0 rd1", c0_nd_o, p_rd_o);
        end
        rx_q0.push_back(p_dout_i);
        @(negedge clk);
        p_nd_i   = 1'b0;
        p_dout_i = '0;
        #1;
        exp_flit = rx_q0.pop_front();
        checks++;
        if (c0_nd_o !== 1'b1 || c0_dout_o !== exp_flit) begin
            failures++;
            $display("FAIL block_second actual=nd%b %h expected=nd1 %h", c0_nd_o, c0_dout_o, exp_flit);
        end
        c0_rd_i = 1'b1;
        @(negedge clk);
        c0_rd_i = 1'b0;
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        p_dout_i = mk(C1A, 16'h7777);
        p_nd_i   = 1'b1;
        @(negedge clk);
        p_nd_i   = 1'b0;
        c1_din_i = mk(C1A, 16'h4242);
        c1_wr_i  = 1'b1;
        p_wait_i = 1'b1;
        #1;
        checks++;
        if (c1_nd_o !== 1'b1) begin
            failures++;
            $display("FAIL arst_setup_nd actual=%b expected=1", c1_nd_o);
        end
        @(negedge clk);
        c1_wr_i = 1'b0;
        #1;
        checks++;
        if (p_wr_o !== 1'b1) begin
            failures++;
            $display("FAIL arst_setup_wr actual=%b expected=1", p_wr_o);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (p_wr_o !== 1'b0 || c1_nd_o !== 1'b0 || p_din_o !== '0 || c1_dout_o !== '0) begin
            failures++;
            $display("FAIL arst_immediate actual=wr%b nd%b %h %h expected=wr0 nd0 0 0",
                     p_wr_o, c1_nd_o, p_din_o, c1_dout_o);
        end
        @(negedge clk);
        rst      = 1'b0;
        p_wait_i = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({p_wr_o, c0_wait_o, c1_wait_o, c1_nd_o} !== 4'b0110) begin
            failures++;
            $display("FAIL arst_after actual=%b expected=0110", {p_wr_o, c0_wait_o, c1_wait_o, c1_nd_o});
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_rx_steer();
        test_rx_block();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
